// File: rtl/ddr_pair_serializer.sv
// ddr_pair_serializer: WIDTH-bit words in, one bit pair per fast clock out,
// LSB first. One holding word sits behind the active shift word. A reload
// that finds the holding register empty substitutes IDLE_WORD and flags it.
module ddr_pair_serializer #(
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       twice,
   output logic             underrun,
   output logic [7:0]       underrun_count
);

   // WIDTH is expected to be even and at least 4, so PAIRS >= 2 and CW >= 1.
   localparam int PAIRS = WIDTH / 2;
   localparam int CW    = $clog2(PAIRS);

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hold;
   logic             r_hold_full;
   logic [1:0]       r_twice;
   logic             r_underrun;
   logic [7:0]       r_ucnt;

   logic             w_last;
   logic             w_accept;
   logic [1:0]       w_pair;

   assign w_last   = (r_cnt == CW'(PAIRS - 1));
   // The holding slot frees up on the last pair because the reload edge
   // empties it at the same time the new word is written.
   assign in_ready = !r_hold_full || w_last;
   assign w_accept = in_valid && in_ready;

   // Pick the pair of the active word addressed by the pair index.
   always_comb begin
      w_pair = r_sh[{r_cnt, 1'b0} +: 2];
   end

   // Pair index and the registered pair feeding the ddr primitive.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_twice <= 2'b00;
      end else begin
         r_twice <= w_pair;
         r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

   // Active word reload and holding register. There is no bypass: a word
   // accepted on the same edge as an empty-hold reload waits one full word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sh        <= IDLE_WORD;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         if (w_last) begin
            r_sh <= r_hold_full ? r_hold : IDLE_WORD;
         end
         if (w_accept) begin
            r_hold      <= in_data;
            r_hold_full <= 1'b1;
         end else if (w_last) begin
            r_hold_full <= 1'b0;
         end
      end
   end

   // Starvation pulse and saturating substitution counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_underrun <= 1'b0;
         r_ucnt     <= 8'd0;
      end else begin
         r_underrun <= w_last && !r_hold_full;
         if (w_last && !r_hold_full && r_ucnt != 8'hFF) begin
            r_ucnt <= r_ucnt + 8'd1;
         end
      end
   end

   assign twice          = r_twice;
   assign underrun       = r_underrun;
   assign underrun_count = r_ucnt;

endmodule
